median9_cx_sequencer: RTL and testbench

Sequential median-of-9 engine for the median-filter stage. It accepts one 3x3 window of unsigned samples and runs Paeth's 19-step compare-exchange network through a single compare-exchange cell, one exchange per clock. It then presents the centre element as the median. It trades throughput (one window per 20 cycles) for area, replacing a 19-comparator combinational network with one comparator plus a 9-entry register file.

---
 rtl/median_pkg.sv | 29 ++
 rtl/bitonic_sort_2.sv | 18 +
 rtl/median9_cx_sequencer.sv | 124 ++++++++++++
 tb/tb_median9_cx_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants and types for the sequential median-of-9 engine:
// tap count, Paeth exchange schedule and the sequencer state encoding.
package median_pkg;

    localparam int NUM_TAPS   = 9;
    localparam int NUM_STEPS  = 19;
    localparam int MEDIAN_IDX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } cx_pair_t;

    // After these 19 exchanges p[4] holds the median; the rest is only partially ordered.
    localparam cx_pair_t CX_SCHEDULE [NUM_STEPS] = '{
        '{4'd1, 4'd2}, '{4'd4, 4'd5}, '{4'd7, 4'd8}, '{4'd0, 4'd1},
        '{4'd3, 4'd4}, '{4'd6, 4'd7}, '{4'd1, 4'd2}, '{4'd4, 4'd5},
        '{4'd7, 4'd8}, '{4'd0, 4'd3}, '{4'd5, 4'd8}, '{4'd4, 4'd7},
        '{4'd3, 4'd6}, '{4'd1, 4'd4}, '{4'd2, 4'd5}, '{4'd4, 4'd7},
        '{4'd4, 4'd2}, '{4'd6, 4'd4}, '{4'd4, 4'd2}
    };

endpackage

// File: rtl/bitonic_sort_2.sv
// Two-input compare-exchange cell: unsigned min on lo, max on hi.
// Equal inputs pass straight through, so ties never swap.
module bitonic_sort_2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic swap;

    assign swap = (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/median9_cx_sequencer.sv
// Median-of-9 engine that walks Paeth's exchange network through a single
// compare-exchange cell, one step per clock, over a 9-entry register file.
module median9_cx_sequencer
    import median_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_TAPS*WIDTH-1:0] i_window,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [WIDTH-1:0]          o_median,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_busy
);

    localparam logic [4:0] LAST_STEP = 5'(NUM_STEPS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       step;
    logic [WIDTH-1:0] p [NUM_TAPS];
    cx_pair_t         pair;
    logic [WIDTH-1:0] cx_lo;
    logic [WIDTH-1:0] cx_hi;
    logic             accept;
    logic             last_step;

    assign pair      = CX_SCHEDULE[step];
    assign accept    = i_valid && o_ready;
    assign last_step = (step == LAST_STEP);

    bitonic_sort_2 #(
        .WIDTH (WIDTH)
    ) u_cx (
        .a  (p[pair.a]),
        .b  (p[pair.b]),
        .lo (cx_lo),
        .hi (cx_hi)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SORT;
            SORT: if (last_step) state_nxt = DONE;
            DONE: if (i_ready) state_nxt = i_valid ? SORT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // o_ready deliberately ignores i_valid so no valid->ready loop exists.
    always_comb begin
        o_ready = 1'b0;
        o_busy  = 1'b0;
        if (!i_rst) begin
            o_ready = (state == IDLE) || ((state == DONE) && i_ready);
        end
        o_busy = (state == SORT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            step     <= '0;
            o_median <= '0;
            o_valid  <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                p[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        step <= '0;
                        for (int k = 0; k < NUM_TAPS; k++) begin
                            p[k] <= i_window[k*WIDTH +: WIDTH];
                        end
                    end
                end
                SORT: begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        if (4'(k) == pair.a) begin
                            p[k] <= cx_lo;
                        end else if (4'(k) == pair.b) begin
                            p[k] <= cx_hi;
                        end
                    end
                    if (last_step) begin
                        // Capture the value landing in the centre tap on this final exchange.
                        o_median <= (pair.a == 4'(MEDIAN_IDX)) ? cx_lo : cx_hi;
                        o_valid  <= 1'b1;
                    end else begin
                        step <= step + 5'd1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (i_valid) begin
                            step <= '0;
                            for (int k = 0; k < NUM_TAPS; k++) begin
                                p[k] <= i_window[k*WIDTH +: WIDTH];
                            end
                        end
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median9_cx_sequencer.sv
// Directed and randomized bench for median9_cx_sequencer: vector table,
// backpressure, back-to-back streaming, async reset mid-sort, random handshakes.
module tb_median9_cx_sequencer;

    localparam int W = 8;
    localparam int NRAND = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [9*W-1:0] win = '0;
    logic          iv = 1'b0;
    logic          ordy;
    logic [W-1:0]  med;
    logic          ov;
    logic          ir = 1'b0;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    median9_cx_sequencer #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_window (win),
        .i_valid  (iv),
        .o_ready  (ordy),
        .o_median (med),
        .o_valid  (ov),
        .i_ready  (ir),
        .o_busy   (busy)
    );

    typedef struct {
        logic [9*W-1:0] w;
        logic [W-1:0]   m;
        string          name;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [9*W-1:0] mk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [W-1:0] model(input logic [9*W-1:0] w);
        logic [W-1:0] s [9];
        logic [W-1:0] t;
        for (int k = 0; k < 9; k++) s[k] = w[k*W +: W];
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0; j--) begin
                if (s[j-1] > s[j]) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            end
        end
        return s[4];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (!ov && n < bound) begin
            tick();
            n++;
        end
        if (!ov) chk("o_valid_timeout", 32'(ov), 32'd1);
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        #1;
        while (!ordy && n < bound) begin
            tick();
            n++;
        end
        if (!ordy) chk("o_ready_timeout", 32'(ordy), 32'd1);
    endtask

    task automatic run_window(input string name, input logic [9*W-1:0] w, input logic [W-1:0] m);
        int n;
        ir  = 1'b1;
        iv  = 1'b1;
        win = w;
        wait_ready(50);
        tick();
        iv  = 1'b0;
        win = ~w;
        chk({name, "_busy"}, 32'(busy), 32'd1);
        wait_valid(40, n);
        chk({name, "_latency"}, 32'(n), 32'd19);
        chk({name, "_median"}, 32'(med), 32'(m));
        tick();
        chk({name, "_valid_drop"}, 32'(ov), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0, t1;
        int sent, got, guard;
        logic [W-1:0] q [$];
        logic [9*W-1:0] wa, wb, wc;

        vecs[0] = '{mk(9,8,7,6,5,4,3,2,1),                 8'd5,   "desc"};
        vecs[1] = '{mk(127,127,127,127,127,127,127,127,127), 8'd127, "all7f"};
        vecs[2] = '{mk(0,255,0,255,0,255,0,255,0),          8'd0,   "alt"};
        vecs[3] = '{mk(255,255,255,255,255,0,0,0,0),        8'd255, "five_ff"};
        vecs[4] = '{mk(1,2,3,4,5,6,7,8,9),                  8'd5,   "asc"};
        vecs[5] = '{mk(3,1,4,1,5,9,2,6,5),                  8'd4,   "pi"};
        vecs[6] = '{mk(0,0,0,0,0,0,0,0,1),                  8'd0,   "one_hot"};
        vecs[7] = '{mk(200,10,250,199,201,7,255,128,90),    8'd199, "mixed"};

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_o_ready", 32'(ordy), 32'd0);
        chk("rst_o_valid", 32'(ov), 32'd0);
        chk("rst_o_busy", 32'(busy), 32'd0);
        chk("rst_o_median", 32'(med), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_o_ready", 32'(ordy), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i].name, vecs[i].w, vecs[i].m);
        end

        // Backpressure: result held, new windows refused
        ir  = 1'b0;
        iv  = 1'b1;
        win = mk(9,8,7,6,5,4,3,2,1);
        wait_ready(50);
        tick();
        iv = 1'b0;
        wait_valid(40, n);
        chk("bp_median", 32'(med), 32'd5);
        for (int i = 0; i < 10; i++) begin
            iv  = 1'b1;
            win = mk(200,200,200,200,200,200,200,200,200);
            #1;
            chk("bp_hold_median", 32'(med), 32'd5);
            chk("bp_hold_valid", 32'(ov), 32'd1);
            chk("bp_hold_ready", 32'(ordy), 32'd0);
            tick();
        end
        iv = 1'b0;
        ir = 1'b1;
        tick();
        chk("bp_consume_valid", 32'(ov), 32'd0);
        chk("bp_consume_busy", 32'(busy), 32'd0);
        chk("bp_consume_ready", 32'(ordy), 32'd1);

        // Back-to-back with i_valid held high
        wa = mk(0,1,2,3,3,9,9,9,9);
        wb = mk(200,200,200,200,200,200,200,200,200);
        wc = mk(30,1,17,50,2,60,3,70,17);
        ir  = 1'b1;
        iv  = 1'b1;
        win = wa;
        wait_ready(50);
        tick();
        win = wb;
        wait_valid(45, n);
        t0 = cyc;
        chk("b2b_med0", 32'(med), 32'd3);
        tick();
        win = wc;
        wait_valid(45, n);
        t1 = cyc;
        chk("b2b_med1", 32'(med), 32'd200);
        chk("b2b_gap1", 32'(t1 - t0), 32'd20);
        tick();
        iv = 1'b0;
        t0 = t1;
        wait_valid(45, n);
        t1 = cyc;
        chk("b2b_med2", 32'(med), 32'd17);
        chk("b2b_gap2", 32'(t1 - t0), 32'd20);
        tick();
        chk("b2b_end_valid", 32'(ov), 32'd0);

        // Asynchronous reset at step 7
        iv  = 1'b1;
        win = mk(9,9,9,9,9,9,9,9,9);
        wait_ready(50);
        tick();
        iv = 1'b0;
        repeat (7) tick();
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ov), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(ordy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_window("after_rst", mk(1,2,3,4,5,6,7,8,9), 8'd5);

        // Random windows and handshake duty
        sent  = 0;
        got   = 0;
        guard = 0;
        while ((sent < NRAND || q.size() != 0) && guard < 20000) begin
            ir = ($urandom_range(0, 2) != 0);
            if (sent < NRAND && $urandom_range(0, 3) != 0) begin
                iv = 1'b1;
                for (int k = 0; k < 9; k++) begin
                    win[k*W +: W] = (sent % 2 == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 3));
                end
            end else begin
                iv = 1'b0;
            end
            #1;
            if (ov && ir) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_extra_result actual=%0d required=none (cycle %0d)", med, cyc);
                end else begin
                    chk("rand_median", 32'(med), 32'(q.pop_front()));
                    got++;
                end
            end
            if (iv && ordy) begin
                q.push_back(model(win));
                sent++;
            end
            tick();
            guard++;
        end
        iv = 1'b0;
        chk("rand_count", 32'(got), 32'(NRAND));
        chk("rand_no_timeout", 32'(guard < 20000), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
